input_debouncer: RTL and testbench

Synchronises and debounces the board's raw asynchronous inputs (8 slide switches, up/down push-buttons) into the CLK_25MHZ domain before they reach the Pong core. Each channel gets a two-flop synchroniser, a per-channel stability counter and a registered clean level, plus single-cycle rise and fall strobes. The block sits between the board pins and Pong in the board top level: RAW_IN comes from SW/BTNU/BTND, CLEAN_OUT drives SWITCHES/BTN_UP/BTN_DOWN.

---
 rtl/input_debouncer.sv | 85 ++++++++
 tb/tb_input_debouncer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus per-channel stability counter for raw board inputs.
// Each channel drives a registered clean level and one-cycle rise/fall strobes.
module input_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             CLK_25MHZ,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] RAW_IN,
    output logic [WIDTH-1:0] CLEAN_OUT,
    output logic [WIDTH-1:0] RISE_OUT,
    output logic [WIDTH-1:0] FALL_OUT
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Bring every raw pin into the clock domain; only r_sync2 is used downstream.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= {WIDTH{1'b0}};
            r_sync2 <= {WIDTH{1'b0}};
        end else begin
            r_sync1 <= RAW_IN;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        chan_state_e      w_state;
        logic             w_flip;
        logic [CNT_W-1:0] r_cnt;
        logic             r_clean;
        logic             r_rise;
        logic             r_fall;

        // Pending whenever the synchronised level disagrees with the clean level.
        always_comb begin
            w_state = (r_sync2[g] != r_clean) ? ST_PENDING : ST_STABLE;
            w_flip  = (w_state == ST_PENDING) && (r_cnt == CNT_MAX);
        end

        // Stability counter, clean level and edge strobes for this channel.
        always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
            if (!RESET_N) begin
                r_cnt   <= {CNT_W{1'b0}};
                r_clean <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                case (w_state)
                    ST_STABLE: begin
                        r_cnt <= {CNT_W{1'b0}};
                    end
                    ST_PENDING: begin
                        if (w_flip) begin
                            r_cnt   <= {CNT_W{1'b0}};
                            r_clean <= r_sync2[g];
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_cnt <= {CNT_W{1'b0}};
                    end
                endcase
                r_rise <= w_flip & r_sync2[g];
                r_fall <= w_flip & ~r_sync2[g];
            end
        end

        assign CLEAN_OUT[g] = r_clean;
        assign RISE_OUT[g]  = r_rise;
        assign FALL_OUT[g]  = r_fall;
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4: the stimulus queues
// hand-computed output events, and a monitor pops one per observed output event.
module tb_input_debouncer;

    localparam int W = 10;

    typedef struct {
        int          cyc;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_out;
    logic [W-1:0] fall_out;

    int  edge_cnt;
    int  checks;
    int  errors;
    ev_t exp_q[$];
    ev_t mon_ev;
    logic [W-1:0] prev_clean;

    input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .CLK_25MHZ(clk),
        .RESET_N  (rst_n),
        .RAW_IN   (raw_in),
        .CLEAN_OUT(clean_out),
        .RISE_OUT (rise_out),
        .FALL_OUT (fall_out)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic push_ev(input int cyc, input logic [W-1:0] c,
                           input logic [W-1:0] r, input logic [W-1:0] f);
        ev_t e;
        e.cyc = cyc; e.clean = c; e.rise = r; e.fall = f;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        checks++;
        if (clean_out !== 10'h000 || rise_out !== 10'h000 || fall_out !== 10'h000) begin
            errors++;
            $display("FAIL %s: clean=%h rise=%h fall=%h, required all 000", tag,
                     clean_out, rise_out, fall_out);
        end
    endtask

    // Monitor: any strobe or clean-level change is an output event to match.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rise_out !== 10'h000 || fall_out !== 10'h000 || clean_out !== prev_clean) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: edge %0d clean=%h rise=%h fall=%h, required no event",
                             edge_cnt, clean_out, rise_out, fall_out);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (mon_ev.cyc != edge_cnt || mon_ev.clean !== clean_out ||
                        mon_ev.rise !== rise_out || mon_ev.fall !== fall_out) begin
                        errors++;
                        $display("FAIL event: got edge %0d clean=%h rise=%h fall=%h, required edge %0d clean=%h rise=%h fall=%h",
                                 edge_cnt, clean_out, rise_out, fall_out,
                                 mon_ev.cyc, mon_ev.clean, mon_ev.rise, mon_ev.fall);
                    end
                end
            end
        end
        prev_clean = clean_out;
    end

    initial begin
        int k;
        edge_cnt   = 0;
        checks     = 0;
        errors     = 0;
        prev_clean = 10'h000;
        rst_n      = 1'b1;
        raw_in     = 10'h3FF;
        #5 rst_n = 1'b0;

        // Reset held with all inputs high: outputs stay low.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_zero("reset_hold");
        end
        rst_n = 1'b1;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h3FF, 10'h3FF, 10'h000);
        tick(8);

        raw_in = 10'h000;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h000, 10'h000, 10'h3FF);
        tick(8);

        // Clean press and release on BTNU.
        raw_in = 10'h100;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h100, 10'h100, 10'h000);
        tick(8);
        raw_in = 10'h000;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h000, 10'h000, 10'h100);
        tick(8);

        // Bounce on BTND: 3 high, 1 low, 3 high, then low -> no event.
        for (int i = 0; i < 8; i++) begin
            raw_in = (i == 3 || i == 7) ? 10'h000 : 10'h200;
            tick(1);
        end
        tick(8);

        // Exactly DEBOUNCE_CYCLES sampled cycles high on SW0.
        raw_in = 10'h001;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h001, 10'h001, 10'h000);
        push_ev(k + 9, 10'h000, 10'h000, 10'h001);
        tick(4);
        raw_in = 10'h000;
        tick(10);

        // Independent channels, then a simultaneous release.
        raw_in = 10'h008;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h008, 10'h008, 10'h000);
        tick(2);
        raw_in = 10'h108;
        push_ev(k + 7, 10'h108, 10'h100, 10'h000);
        tick(8);
        raw_in = 10'h000;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h000, 10'h000, 10'h108);
        tick(8);

        // Reset mid-count on SW1 discards the pending rise.
        raw_in = 10'h002;
        k = edge_cnt + 1;
        tick(3);
        rst_n = 1'b0;
        #1 chk_zero("reset_midcount");
        tick(1);
        chk_zero("reset_midcount_hold");
        rst_n = 1'b1;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h002, 10'h002, 10'h000);
        tick(8);
        raw_in = 10'h000;
        k = edge_cnt + 1;
        push_ev(k + 5, 10'h000, 10'h000, 10'h002);
        tick(10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events not seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
